// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding and PC source codes.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // PC source mux select codes; 2'b11 is never produced.
  localparam logic [1:0] SEL_ALU    = 2'b00;
  localparam logic [1:0] SEL_REG    = 2'b01;
  localparam logic [1:0] SEL_CONCAT = 2'b10;

  // Width of the fetch wait counter (covers timeouts up to 65535).
  localparam int WAIT_W = 16;

endpackage

// File: rtl/pc_sequencer_watchdog.sv
// Fetch watchdog: counts FETCH cycles spent waiting on instruction memory
// and flags the wait cycle on which the timeout limit is reached.
module fetch_watchdog
  import pc_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic wait_cycle,
  output logic expired
);

  // The Nth wait cycle sees a count of N-1, so compare against limit-1.
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(FETCH_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Wait counter: held at zero outside active FETCH, counts unanswered requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (wait_cycle) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expired = wait_cycle && (wait_cnt == LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH/DECODE/EXEC/COMMIT control with absorbing
// HALT and fetch-timeout FAULT states, plus a retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ready,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic        is_halt,
  input  logic        alu_zero,
  output logic [1:0]  sel_pc,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_req,
  output logic        fault,
  output logic [2:0]  state_dbg,
  output logic [15:0] instr_count
);

  state_t state;
  logic   running;   // low until the first clock edge after reset release
  logic   zero_q;    // alu_zero captured at the end of EXEC
  logic   fetching;
  logic   expired;

  assign fetching  = running && (state == ST_FETCH);
  assign state_dbg = state;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (!fetching),
    .wait_cycle(fetching && !mem_ready),
    .expired   (expired)
  );

  // Control FSM: state transitions, zero flag capture, retire count, sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      running     <= 1'b0;
      zero_q      <= 1'b0;
      instr_count <= '0;
      fault       <= 1'b0;
    end else begin
      running <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (running) begin
            if (mem_ready) begin
              state <= ST_DECODE;
            end else if (expired) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end
        end
        ST_DECODE: state <= is_halt ? ST_HALT : ST_EXEC;
        ST_EXEC: begin
          zero_q <= alu_zero;
          state  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          instr_count <= instr_count + 16'd1;
          state       <= ST_FETCH;
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_FETCH;
      endcase
    end
  end

  // Enables: Mealy in FETCH (memory handshake) and COMMIT (PC source priority).
  always_comb begin
    mem_req  = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    sel_pc   = SEL_ALU;
    case (state)
      ST_FETCH: begin
        if (running) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            sel_pc   = SEL_ALU;
          end
        end
      end
      ST_COMMIT: begin
        if (is_jr) begin
          pc_write = 1'b1;
          sel_pc   = SEL_REG;
        end else if (is_jump) begin
          pc_write = 1'b1;
          sel_pc   = SEL_CONCAT;
        end else if (is_branch && zero_q) begin
          pc_write = 1'b1;
          sel_pc   = SEL_ALU;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven, scoreboarded bench for pc_sequencer (FETCH_TIMEOUT = 4).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ready = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
  logic        is_jr = 1'b0, is_halt = 1'b0, alu_zero = 1'b0;
  logic [1:0]  sel_pc;
  logic        pc_write, ir_write, mem_req, fault;
  logic [2:0]  state_dbg;
  logic [15:0] instr_count;

  pc_sequencer #(.FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .is_branch(is_branch),
    .is_jump(is_jump), .is_jr(is_jr), .is_halt(is_halt), .alu_zero(alu_zero),
    .sel_pc(sel_pc), .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req),
    .fault(fault), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mr, br, jmp, jr, hlt, az;
    logic [2:0]  st;
    logic        mreq, irw, pcw;
    logic [1:0]  sel;
    logic        flt;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t v(logic rst, logic mr, logic br, logic jmp, logic jr,
                             logic hlt, logic az, logic [2:0] st, logic mreq,
                             logic irw, logic pcw, logic [1:0] sel, logic flt,
                             logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.mr = mr; r.br = br; r.jmp = jmp; r.jr = jr; r.hlt = hlt;
    r.az = az; r.st = st; r.mreq = mreq; r.irw = irw; r.pcw = pcw; r.sel = sel;
    r.flt = flt; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_idle_reset(string tag);
    chk({tag, ".state"}, 16'(state_dbg), 16'd0);
    chk({tag, ".mem_req"}, 16'(mem_req), 16'd0);
    chk({tag, ".ir_write"}, 16'(ir_write), 16'd0);
    chk({tag, ".pc_write"}, 16'(pc_write), 16'd0);
    chk({tag, ".sel_pc"}, 16'(sel_pc), 16'd0);
    chk({tag, ".fault"}, 16'(fault), 16'd0);
    chk({tag, ".count"}, instr_count, 16'd0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    {mem_ready, is_branch, is_jump, is_jr, is_halt, alu_zero} = '0;
    #1;
    chk_idle_reset({tag, ".rst"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, ".pre_run_mem_req"}, 16'(mem_req), 16'd0);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic run_vec(vec_t t, int idx);
    vec_t e;
    string p;
    @(posedge clk);
    #1;
    mem_ready = t.mr; is_branch = t.br; is_jump = t.jmp;
    is_jr = t.jr; is_halt = t.hlt; alu_zero = t.az;
    exp_q.push_back(t);
    @(negedge clk);
    e = exp_q.pop_front();
    p = $sformatf("v%0d", idx);
    chk({p, ".state"}, 16'(state_dbg), 16'(e.st));
    chk({p, ".mem_req"}, 16'(mem_req), 16'(e.mreq));
    chk({p, ".ir_write"}, 16'(ir_write), 16'(e.irw));
    chk({p, ".pc_write"}, 16'(pc_write), 16'(e.pcw));
    chk({p, ".sel_pc"}, 16'(sel_pc), 16'(e.sel));
    chk({p, ".fault"}, 16'(fault), 16'(e.flt));
    chk({p, ".count"}, instr_count, e.cnt);
  endtask

  initial begin
    // Plain ALU instruction, memory always ready: 0,1,2,3,0.
    tbl.push_back(v(1, 1,0,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd3, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd1));
    // jr + jump together -> register source; then jump alone -> concat.
    tbl.push_back(v(1, 1,0,1,1,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,1,1,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,1,1,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,1,1,1,0,1, 3'd3, 0,0,1, 2'b01, 0, 16'd0));
    tbl.push_back(v(0, 1,0,1,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 1,0,1,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 1,0,1,0,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 1,1,1,0,0,0, 3'd3, 0,0,1, 2'b10, 0, 16'd1));
    // Branch not taken (zero=0), then taken (zero=1).
    tbl.push_back(v(0, 1,1,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd2));
    tbl.push_back(v(0, 1,1,0,0,0,1, 3'd1, 0,0,0, 2'b00, 0, 16'd2));
    tbl.push_back(v(0, 1,1,0,0,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd2));
    tbl.push_back(v(0, 1,1,0,0,0,1, 3'd3, 0,0,0, 2'b00, 0, 16'd2));
    tbl.push_back(v(0, 1,1,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd3));
    tbl.push_back(v(0, 1,1,0,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd3));
    tbl.push_back(v(0, 1,1,0,0,0,1, 3'd2, 0,0,0, 2'b00, 0, 16'd3));
    tbl.push_back(v(0, 1,1,0,0,0,0, 3'd3, 0,0,1, 2'b00, 0, 16'd3));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd4));
    // Timeout: four unanswered wait cycles -> FAULT, absorbing.
    tbl.push_back(v(1, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 1,0,1,1,0,1, 3'd5, 0,0,0, 2'b00, 1, 16'd0));
    // Ready arrives on the fourth wait cycle: DECODE wins; counter re-arms per fetch.
    tbl.push_back(v(1, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd3, 0,0,0, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 1,0,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd1));
    tbl.push_back(v(0, 0,0,0,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd1));
    // Halt: DECODE with is_halt -> HALT, all enables low for 20 cycles.
    tbl.push_back(v(1, 1,0,0,0,1,0, 3'd0, 1,1,1, 2'b00, 0, 16'd0));
    tbl.push_back(v(0, 1,0,0,0,1,0, 3'd1, 0,0,0, 2'b00, 0, 16'd0));
    for (int i = 0; i < 20; i++)
      tbl.push_back(v(0, 1,1,1,1,0,1, 3'd4, 0,0,0, 2'b00, 0, 16'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("r%0d", i));
      run_vec(tbl[i], i);
    end

    // Reset pulsed during EXEC: immediate return to FETCH, nothing retired.
    do_reset("mid");
    run_vec(v(0, 1,0,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd0), 100);
    run_vec(v(0, 1,0,0,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd0), 101);
    run_vec(v(0, 1,0,0,0,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd0), 102);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_reset("mid_exec");
    @(posedge clk);
    #1;
    chk("mid_exec.held_count", instr_count, 16'd0);
    chk("mid_exec.held_state", 16'(state_dbg), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(v(0, 1,0,0,0,0,0, 3'd0, 1,1,1, 2'b00, 0, 16'd0), 103);
    run_vec(v(0, 1,0,0,0,0,0, 3'd1, 0,0,0, 2'b00, 0, 16'd0), 104);
    run_vec(v(0, 1,0,0,0,0,0, 3'd2, 0,0,0, 2'b00, 0, 16'd0), 105);
    run_vec(v(0, 1,0,0,0,0,0, 3'd3, 0,0,0, 2'b00, 0, 16'd0), 106);
    run_vec(v(0, 0,0,0,0,0,0, 3'd0, 1,0,0, 2'b00, 0, 16'd1), 107);

    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one parameter: FETCH_TIMEOUT, default 255, the maximum number of FETCH wait cycles before a fault is raised (1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port mem_ready, input, 1 bit: instruction memory has valid data this cycle.
REQ-005 The block SHALL have port is_branch, input, 1 bit: the decoded instruction is a conditional branch.
REQ-006 The block SHALL have port is_jump, input, 1 bit: the decoded instruction is a direct jump (concatenated target).
REQ-007 The block SHALL have port is_jr, input, 1 bit: the decoded instruction is a register jump.
REQ-008 The block SHALL have port is_halt, input, 1 bit: the decoded instruction is a halt.
REQ-009 The block SHALL have port alu_zero, input, 1 bit: ALU zero flag, valid in EXEC.
REQ-010 The block SHALL have port sel_pc, output, 2 bits: PC source select (00 ALU, 01 register, 10 concatenated jump).
REQ-011 The block SHALL have port pc_write, output, 1 bit: PC load enable.
REQ-012 The block SHALL have port ir_write, output, 1 bit: instruction register load enable.
REQ-013 The block SHALL have port mem_req, output, 1 bit: instruction fetch request.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky fetch-timeout indication.
REQ-015 The block SHALL have port state_dbg, output, 3 bits: current state encoding.
REQ-016 The block SHALL have port instr_count, output, 16 bits: number of retired instructions.

Function
REQ-017 The states SHALL be FETCH=0, DECODE=1, EXEC=2, COMMIT=3, HALT=4 and FAULT=5; state_dbg SHALL equal the current state.
REQ-018 In FETCH, mem_req SHALL be 1. If mem_ready=1, ir_write=1, pc_write=1 and sel_pc=00 (PC+4) SHALL be asserted in that same cycle (Mealy) and the next state SHALL be DECODE; otherwise the block SHALL stay in FETCH.
REQ-019 A wait counter SHALL clear on FETCH entry and increment for each FETCH cycle with mem_ready=0. On reaching FETCH_TIMEOUT, the next state SHALL be FAULT. mem_ready=1 in the same cycle as the timeout SHALL win, and the next state SHALL be DECODE.
REQ-020 From DECODE, if is_halt=1 the next state SHALL be HALT; otherwise it SHALL be EXEC. DECODE lasts exactly 1 cycle.
REQ-021 EXEC SHALL last exactly 1 cycle, then go to COMMIT; the block SHALL register alu_zero at the end of EXEC.
REQ-022 COMMIT SHALL last 1 cycle, then go to FETCH, with PC update priority is_jr > is_jump > is_branch:
- is_jr: sel_pc=01, pc_write=1.
- is_jump: sel_pc=10, pc_write=1.
- is_branch and registered zero=1: sel_pc=00, pc_write=1.
- Otherwise: pc_write=0.
REQ-023 instr_count SHALL increment by 1 on every COMMIT cycle and wrap from 0xFFFF to 0x0000.
REQ-024 HALT and FAULT SHALL be absorbing states, exited only by reset. In both, all enables SHALL be 0; fault SHALL be 1 in FAULT only.
REQ-025 sel_pc SHALL never be 11 and SHALL be 00 whenever pc_write=0.
REQ-026 With FETCH_TIMEOUT=1 and a pipeline-free memory, a non-control instruction SHALL retire in 4 cycles: FETCH, DECODE, EXEC, COMMIT.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously set state=FETCH, wait counter=0, registered zero=0, instr_count=0 and fault=0.
REQ-028 During reset the outputs SHALL be mem_req=0, pc_write=0, ir_write=0 and sel_pc=00; mem_req SHALL rise on the first clock edge after rst_n rises.
REQ-029 Reset asserted mid-instruction SHALL abandon the instruction without incrementing instr_count.

Structure
REQ-030 The state encoding and the sel_pc codes (SEL_ALU, SEL_REG, SEL_CONCAT) SHALL reside in a shared package also used by the PC source mux.
REQ-031 The fetch-timeout counter SHALL be a sub-module named fetch_watchdog; the rest of the block SHALL be a single FSM.

Verification
REQ-032 The bench SHALL cover: mem_ready tied to 1 with a plain ALU instruction -> state sequence 0,1,2,3,0; ir_write and pc_write high with sel_pc=00 in cycle 1; instr_count=1 after COMMIT.
REQ-033 The bench SHALL cover: is_jr=1 and is_jump=1 together -> COMMIT gives sel_pc=01, pc_write=1.
REQ-034 The bench SHALL cover: is_branch=1 with alu_zero=0 in EXEC -> COMMIT gives pc_write=0, sel_pc=00; repeated with alu_zero=1 -> pc_write=1.
REQ-035 The bench SHALL cover: FETCH_TIMEOUT=4 with mem_ready held 0 -> FAULT (state_dbg=5, fault=1) after 4 wait cycles, persisting until reset; mem_ready=1 on the 4th wait cycle -> DECODE instead.
REQ-036 The bench SHALL cover: is_halt=1 in DECODE -> HALT, with all enables 0 for 20 cycles.
REQ-037 The bench SHALL cover: rst_n pulsed low during EXEC -> immediate return to FETCH, instr_count unchanged at 0.
